// File: rtl/fir_mac_u.sv
// Time-multiplexed FIR multiply-accumulate: snapshots the tap vector on VIN, walks
// one product per cycle, emits one sample per accept. `FIR_MAC_SAT_EN selects clamp vs wrap.
module fir_mac_u #(
  parameter int unsigned DATA_WIDTH = 13,
  parameter int unsigned COEF_WIDTH = 13,
  parameter int unsigned TAPS       = 8,
  parameter int unsigned OUT_WIDTH  = 16
) (
  input  logic                          CLK,
  input  logic                          RST_n,
  input  logic                          VIN,
  input  logic signed [DATA_WIDTH-1:0]  tp [0:TAPS-1],
  input  logic                          COEF_WE,
  input  logic [$clog2(TAPS)-1:0]       COEF_ADDR,
  input  logic signed [COEF_WIDTH-1:0]  COEF_DATA,
  output logic                          BUSY,
  output logic                          VOUT,
  output logic signed [OUT_WIDTH-1:0]   DOUT,
  output logic                          OVF
);

  localparam int unsigned AW     = $clog2(TAPS);
  localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int unsigned ACC_W  = PROD_W + AW;
  localparam int unsigned SHIFT  = COEF_WIDTH - 1;
  localparam logic [AW-1:0] LAST     = AW'(TAPS - 1);
  localparam logic [AW:0]   TAPS_EXT = (AW + 1)'(TAPS);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t                       state;
  logic [AW-1:0]                cnt;
  logic signed [ACC_W-1:0]      acc;
  logic signed [DATA_WIDTH-1:0] snap [0:TAPS-1];
  logic signed [COEF_WIDTH-1:0] coef [0:TAPS-1];

  logic signed [PROD_W-1:0]     prod_c;
  logic signed [ACC_W-1:0]      acc_sum_c;
  logic signed [OUT_WIDTH-1:0]  dout_c;
  logic                         addr_ok_c;

`ifdef FIR_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted_c;
`endif

  // Current product, running sum and the narrowed result of that sum
  always_comb begin
    prod_c    = PROD_W'(snap[cnt]) * PROD_W'(coef[cnt]);
    acc_sum_c = acc + ACC_W'(prod_c);
    addr_ok_c = {1'b0, COEF_ADDR} < TAPS_EXT;
`ifdef FIR_MAC_SAT_EN
    shifted_c = acc_sum_c >>> SHIFT;
    if (shifted_c > SAT_MAX)
      dout_c = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (shifted_c < SAT_MIN)
      dout_c = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      dout_c = shifted_c[OUT_WIDTH-1:0];
`else
    dout_c = acc_sum_c[SHIFT +: OUT_WIDTH];
`endif
  end

  // Control FSM, datapath registers and coefficient file
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      BUSY  <= 1'b0;
      VOUT  <= 1'b0;
      DOUT  <= '0;
      OVF   <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) begin
        snap[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      VOUT <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (VIN) begin
            snap  <= tp;
            acc   <= '0;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= S_ACC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACC: begin
          acc <= acc_sum_c;
          cnt <= cnt + AW'(1);
          if (VIN) OVF <= 1'b1;
          if (cnt == LAST) begin
            BUSY  <= 1'b0;
            VOUT  <= 1'b1;
            DOUT  <= dout_c;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Writes are locked out while products are being walked
      if (COEF_WE && (state != S_ACC) && addr_ok_c)
        coef[COEF_ADDR] <= COEF_DATA;
    end
  end

endmodule

// File: tb/tb_fir_mac_u.sv
// Bench for fir_mac_u: scoreboard of expected samples checked on every VOUT,
// plus a TAPS=6 instance for coefficient address bounds.
module tb_fir_mac_u;
  localparam int unsigned DW = 13, CW = 13, TAPS = 8, OW = 16, TAPS6 = 6;

  logic CLK = 1'b0, RST_n = 1'b0, VIN = 1'b0, COEF_WE = 1'b0;
  logic signed [DW-1:0] tp [0:TAPS-1];
  logic [2:0] COEF_ADDR = '0;
  logic signed [CW-1:0] COEF_DATA = '0;
  logic BUSY, VOUT, OVF;
  logic signed [OW-1:0] DOUT;

  logic vin6 = 1'b0, we6 = 1'b0;
  logic signed [DW-1:0] tp6 [0:TAPS6-1];
  logic [2:0] addr6 = '0;
  logic signed [CW-1:0] data6 = '0;
  logic busy6, vout6, ovf6;
  logic signed [OW-1:0] dout6;

  int total = 0, bad = 0;
  logic signed [OW-1:0] exp_q [$];
  logic signed [OW-1:0] mon_exp;
  int coef_m [0:TAPS-1];

  fir_mac_u #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAPS(TAPS), .OUT_WIDTH(OW)) u_dut (
    .CLK(CLK), .RST_n(RST_n), .VIN(VIN), .tp(tp), .COEF_WE(COEF_WE),
    .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA), .BUSY(BUSY), .VOUT(VOUT),
    .DOUT(DOUT), .OVF(OVF));

  fir_mac_u #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .TAPS(TAPS6), .OUT_WIDTH(OW)) u_dut6 (
    .CLK(CLK), .RST_n(RST_n), .VIN(vin6), .tp(tp6), .COEF_WE(we6),
    .COEF_ADDR(addr6), .COEF_DATA(data6), .BUSY(busy6), .VOUT(vout6),
    .DOUT(dout6), .OVF(ovf6));

  always #5 CLK = ~CLK;

  // Scoreboard: every VOUT pops one expected sample
  always @(negedge CLK) begin
    if (RST_n && VOUT) begin
      total += 2;
      if (BUSY) begin
        bad++;
        $display("FAIL busy_vout_overlap busy=%0b vout=%0b required busy=0", BUSY, VOUT);
      end
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_vout dout=%0d required no VOUT", DOUT);
      end else begin
        mon_exp = exp_q.pop_front();
        if (DOUT !== mon_exp) begin
          bad++;
          $display("FAIL scoreboard_dout got=%0d required=%0d", DOUT, mon_exp);
        end
      end
    end
  end

  function automatic logic signed [OW-1:0] model_out();
    longint acc = 0;
    longint sh;
    for (int i = 0; i < int'(TAPS); i++) acc += longint'(tp[i]) * longint'(coef_m[i]);
    sh = acc >>> 12;
`ifdef FIR_MAC_SAT_EN
    if (sh > 32767) sh = 32767;
    else if (sh < -32768) sh = -32768;
`endif
    return OW'(sh);
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic set_taps(input int v);
    for (int i = 0; i < int'(TAPS); i++) tp[i] = DW'(v);
  endtask

  task automatic rand_taps();
    for (int i = 0; i < int'(TAPS); i++) tp[i] = DW'(int'($urandom_range(0, 8000)) - 4000);
  endtask

  task automatic write_coef(input int a, input int d);
    COEF_WE = 1'b1; COEF_ADDR = 3'(a); COEF_DATA = CW'(d);
    tick();
    COEF_WE = 1'b0;
    coef_m[a] = d;
  endtask

  task automatic start();
    exp_q.push_back(model_out());
    VIN = 1'b1;
    tick();
    VIN = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      @(negedge CLK); #1;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_dout(input string name, input logic signed [OW-1:0] e);
    total++;
    if (DOUT !== e) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, DOUT, e);
    end
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    for (int i = 0; i < int'(TAPS); i++) coef_m[i] = 0;
    set_taps(0);
    for (int i = 0; i < int'(TAPS6); i++) tp6[i] = '0;
    repeat (3) tick();
    total += 4;
    if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b required=0", BUSY); end
    if (VOUT !== 1'b0) begin bad++; $display("FAIL reset_vout got=%0b required=0", VOUT); end
    if (DOUT !== '0)   begin bad++; $display("FAIL reset_dout got=%0d required=0", DOUT); end
    if (OVF !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%0b required=0", OVF); end
    RST_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    for (int a = 0; a < int'(TAPS); a++) write_coef(a, 2048);
    set_taps(100);
    start();
    for (int c = 1; c <= int'(TAPS); c++) begin
      @(negedge CLK);
      total++;
      if (BUSY !== 1'b1 || VOUT !== 1'b0) begin
        bad++;
        $display("FAIL pass_busy cycle=%0d busy=%0b vout=%0b required busy=1 vout=0", c, BUSY, VOUT);
      end
      tick();
    end
    @(negedge CLK);
    total++;
    if (VOUT !== 1'b1 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL pass_vout cycle=9 vout=%0b busy=%0b required vout=1 busy=0", VOUT, BUSY);
    end
    check_dout("pass_dout", 16'sd400);
    wait_drain("pass");
  endtask

  task automatic test_impulse();
    for (int a = 0; a < int'(TAPS); a++) write_coef(a, 256 * a);
    set_taps(0);
    tp[3] = 13'sd1000;
    start();
    wait_drain("impulse");
    check_dout("impulse_dout", 16'sd187);
  endtask

  task automatic test_saturation();
    for (int a = 0; a < int'(TAPS); a++) write_coef(a, -4096);
    set_taps(-4096);
    start();
    wait_drain("sat");
`ifdef FIR_MAC_SAT_EN
    check_dout("sat_dout", 16'sd32767);
`else
    check_dout("wrap_dout", -16'sd32768);
`endif
  endtask

  task automatic test_back_to_back();
    logic signed [OW-1:0] exp_b;
    for (int a = 0; a < int'(TAPS); a++) write_coef(a, int'($urandom_range(0, 4000)) - 2000);
    rand_taps();
    start();                                  // cycle 0
    for (int c = 1; c <= 3; c++) begin rand_taps(); tick(); end
    @(negedge CLK);                           // cycle 4
    total++;
    if (OVF !== 1'b0) begin bad++; $display("FAIL ovf_before_drop got=%0b required=0", OVF); end
    VIN = 1'b1; rand_taps();
    tick();                                   // cycle 5
    VIN = 1'b0;
    COEF_WE = 1'b1; COEF_ADDR = 3'd0; COEF_DATA = CW'(coef_m[0] > 0 ? coef_m[0] - 1500 : coef_m[0] + 1500);
    @(negedge CLK);
    total++;
    if (OVF !== 1'b1) begin bad++; $display("FAIL ovf_after_drop got=%0b required=1", OVF); end
    tick();                                   // cycle 6
    COEF_WE = 1'b0;
    for (int c = 6; c <= 8; c++) begin rand_taps(); tick(); end
    @(negedge CLK);                           // cycle 9
    total++;
    if (VOUT !== 1'b1) begin bad++; $display("FAIL b2b_first_vout got=%0b required=1", VOUT); end
    rand_taps();
    tp[0] = 13'sd1500;
    exp_b = model_out();
    exp_q.push_back(exp_b);
    VIN = 1'b1;
    tick();                                   // cycle 10
    VIN = 1'b0;
    for (int c = 10; c <= 18; c++) begin
      rand_taps();
      @(negedge CLK);
      total++;
      if (VOUT !== (c == 18)) begin
        bad++;
        $display("FAIL b2b_second_vout cycle=%0d got=%0b required=%0b", c, VOUT, c == 18);
      end
      tick();
    end
    wait_drain("b2b");
    check_dout("b2b_held_dout", exp_b);
  endtask

  task automatic test_reset_mid();
    set_taps(300);
    VIN = 1'b1;
    tick();
    VIN = 1'b0;
    repeat (3) tick();                        // now in cycle 4
    RST_n = 1'b0;
    #1;
    total += 4;
    if (BUSY !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b required=0", BUSY); end
    if (VOUT !== 1'b0) begin bad++; $display("FAIL midrst_vout got=%0b required=0", VOUT); end
    if (DOUT !== '0)   begin bad++; $display("FAIL midrst_dout got=%0d required=0", DOUT); end
    if (OVF !== 1'b0)  begin bad++; $display("FAIL midrst_ovf got=%0b required=0", OVF); end
    tick();
    RST_n = 1'b1;
    for (int i = 0; i < int'(TAPS); i++) coef_m[i] = 0;
    repeat (12) tick();
    set_taps(100);
    start();
    wait_drain("readback");
    check_dout("readback_dout", 16'sd0);
  endtask

  task automatic write6(input int a, input int d);
    we6 = 1'b1; addr6 = 3'(a); data6 = CW'(d);
    tick();
    we6 = 1'b0;
  endtask

  task automatic run6(input string name, input logic signed [OW-1:0] e);
    int found;
    found = -1;
    vin6 = 1'b1;
    tick();
    vin6 = 1'b0;
    for (int k = 0; k < 20 && found < 0; k++) begin
      @(negedge CLK);
      if (vout6) found = k;
      #1;
    end
    total += 2;
    if (found < 0) begin
      bad += 2;
      $display("FAIL %s_timeout no VOUT within 20 cycles required VOUT", name);
    end else begin
      if (found != int'(TAPS6)) begin
        bad++;
        $display("FAIL %s_latency got=%0d required=%0d", name, found + 1, TAPS6 + 1);
      end
      if (dout6 !== e) begin
        bad++;
        $display("FAIL %s_dout got=%0d required=%0d", name, dout6, e);
      end
    end
  endtask

  task automatic test_addr_bounds();
    for (int a = 0; a < int'(TAPS6); a++) write6(a, 2048);
    for (int i = 0; i < int'(TAPS6); i++) tp6[i] = 13'sd100;
    run6("addr_base", 16'sd300);
    write6(7, 1000);
    write6(6, -1000);
    run6("addr_oob", 16'sd300);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_impulse();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_addr_bounds();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
